// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default FIFO depth and TX sequencer states.
package uart_pkg;

    localparam int unsigned UART_DATA_W         = 8;
    localparam int unsigned UART_FIFO_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle between the UART receiver/transmitter and the TX FIFO sequencer.
// The environment (receiver, transmitter) is the master side; the FIFO block is the slave.
interface uart_tx_fifo_if #(
    parameter int unsigned DEPTH = uart_pkg::UART_FIFO_DEPTH_DEF
);
    import uart_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_done;
    logic                   tx_busy;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_start;
    logic                   empty;
    logic                   full;
    logic [ADDR_W:0]        count;
    logic                   overflow;
    logic [7:0]             drop_cnt;

    modport master (
        output rx_data, rx_done, tx_busy,
        input  tx_data, tx_start, empty, full, count, overflow, drop_cnt
    );

    modport slave (
        input  rx_data, rx_done, tx_busy,
        output tx_data, tx_start, empty, full, count, overflow, drop_cnt
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte FIFO with wrap-bit pointers; push is refused when full, pop when empty.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned  DEPTH  = UART_FIFO_DEPTH_DEF,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [UART_DATA_W-1:0] i_wdata,
    input  logic                   i_pop,
    output logic [UART_DATA_W-1:0] o_rdata,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [ADDR_W:0]        o_count
);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]        r_wr_ptr;
    logic [ADDR_W:0]        r_rd_ptr;
    logic                   w_push_ok;
    logic                   w_pop_ok;

    // Full: same slot, opposite lap. Empty: identical pointers.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                       (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_rdata   = r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Fullness is judged before any same-cycle pop, so a pop never frees room for a push.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
        end
    end

    // Pointer update; both wrap naturally at 2^(ADDR_W+1).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers received bytes and feeds them to the UART transmitter one frame at a time.
// Optional drop statistics (overflow flag, drop counter) are built when
// UART_TX_FIFO_OVF_STAT_EN is defined; otherwise those outputs are constant 0.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    uart_tx_fifo_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    tx_fifo_state_t         r_state;
    tx_fifo_state_t         w_state_d;
    logic                   w_pop;
    logic [UART_DATA_W-1:0] w_rdata;
    logic                   w_empty;
    logic                   w_full;
    logic [ADDR_W:0]        w_count;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic                   r_tx_start;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (bus.rx_done),
        .i_wdata (bus.rx_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Next-state logic; a pop happens only on the Idle->Start transition.
    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty && !bus.tx_busy) begin
                    w_pop     = 1'b1;
                    w_state_d = StStart;
                end
            end
            StStart:    w_state_d = StWaitBusy;
            StWaitBusy: if (bus.tx_busy)  w_state_d = StWaitDone;
            StWaitDone: if (!bus.tx_busy) w_state_d = StIdle;
            default:    w_state_d = StIdle;
        endcase
    end

    // State register plus registered transmitter outputs; tx_start is high exactly in Start.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_tx_start <= w_pop;
            if (w_pop) r_tx_data <= w_rdata;
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_start = r_tx_start;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = w_count;

`ifdef UART_TX_FIFO_OVF_STAT_EN
    logic       w_drop;
    logic       r_overflow;
    logic [7:0] r_drop_cnt;

    assign w_drop = bus.rx_done && w_full;

    // Sticky overflow flag and saturating count of refused pushes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.overflow = r_overflow;
    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.overflow = 1'b0;
    assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based model checked every cycle,
// plus literal expectations per scenario.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Transmitter model: busy rises the cycle after a start, for busy_len cycles.
    logic hold_busy  = 1'b0;
    logic model_busy = 1'b0;
    logic pend       = 1'b0;
    int   busy_cnt   = 0;
    int   busy_len   = 100;
    assign bus.tx_busy = hold_busy | model_busy;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [7:0] exp_tx    = 8'h00;
    logic       m_ovf     = 1'b0;
    int         m_drop    = 0;
    int         cyc       = 0;
    int         push_cyc  = 0;
    int         start_cyc = 0;
    int         max_count = 0;
    logic       coinc     = 1'b0;
    logic       busy_seen = 1'b1;
    logic       prev_rst  = 1'b1;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_busy = 1'b0;

    // Compare process: apply the inputs sampled at the last edge to the model, then check.
    always @(negedge clk) begin
        int pre;
        cyc++;
        if (prev_rst) begin
            q.delete();
            exp_tx = 8'h00;
            m_ovf  = 1'b0;
            m_drop = 0;
            chk("start_in_reset", {31'd0, bus.tx_start}, 32'd0);
        end else begin
            pre = q.size();
            if (prev_done) begin
                if (pre < DEPTH) q.push_back(prev_data);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (bus.tx_start) begin
                chk("start_nonempty", {31'd0, pre > 0}, 32'd1);
                chk("start_tx_idle", {31'd0, prev_busy}, 32'd0);
                chk("one_start_per_busy", {31'd0, busy_seen}, 32'd1);
                if (pre > 0) begin
                    if (prev_done && pre < DEPTH) coinc = 1'b1;
                    exp_tx = q.pop_front();
                end
                sent.push_back(bus.tx_data);
                start_cyc = cyc;
                busy_seen = 1'b0;
            end
        end
        if (bus.tx_busy) busy_seen = 1'b1;
        if (q.size() > max_count) max_count = q.size();
        chk("count", 32'(bus.count), q.size());
        chk("empty", {31'd0, bus.empty}, {31'd0, q.size() == 0});
        chk("full", {31'd0, bus.full}, {31'd0, q.size() == DEPTH});
        chk("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_tx});
`ifdef UART_TX_FIFO_OVF_STAT_EN
        chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
        chk("drop_cnt", {24'd0, bus.drop_cnt}, m_drop);
`else
        chk("overflow", {31'd0, bus.overflow}, 32'd0);
        chk("drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
`endif
        prev_rst  = rst;
        prev_done = bus.rx_done;
        prev_data = bus.rx_data;
        prev_busy = bus.tx_busy;
        if (bus.rx_done) push_cyc = cyc;
    end

    // One clock: advance the transmitter model and drive the receiver inputs.
    task automatic step(input logic d, input logic [7:0] v);
        @(posedge clk);
        #1;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end
        if (pend) begin
            model_busy = 1'b1;
            busy_cnt   = busy_len;
            pend       = 1'b0;
        end
        if (bus.tx_start) pend = 1'b1;
        bus.rx_done = d;
        bus.rx_data = v;
    endtask

    task automatic wait_idle(input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (q.size() == 0 && !bus.tx_busy && !pend && !bus.tx_start) begin
                ok = 1'b1;
                break;
            end
            step(1'b0, 8'h00);
        end
        chk("drain_timeout", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    endtask

    initial begin
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b0;
        step(1'b0, 8'h00);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_empty", {31'd0, bus.empty}, 32'd1);
        chk("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);

        // Single byte
        sent.delete();
        busy_len = 100;
        step(1'b1, 8'h30);
        step(1'b0, 8'h00);
        wait_idle(300);
        chk("single_n_sent", sent.size(), 32'd1);
        if (sent.size() >= 1) chk("single_byte", {24'd0, sent[0]}, 32'h30);
        chk("single_latency", start_cyc - push_cyc, 32'd2);
        chk("single_empty", {31'd0, bus.empty}, 32'd1);
        chk("single_count", 32'(bus.count), 32'd0);

        // Burst behind a busy transmitter
        sent.delete();
        busy_len  = 5;
        hold_busy = 1'b1;
        step(1'b1, 8'h41);
        step(1'b1, 8'h42);
        step(1'b1, 8'h43);
        step(1'b0, 8'h00);
        chk("burst_count", 32'(bus.count), 32'd3);
        step(1'b0, 8'h00);
        hold_busy = 1'b0;
        wait_idle(200);
        chk("burst_n_sent", sent.size(), 32'd3);
        for (int i = 0; i < 3 && i < sent.size(); i++)
            chk("burst_order", {24'd0, sent[i]}, 32'h41 + i);

        // Fill past capacity
        sent.delete();
        busy_len  = 4;
        hold_busy = 1'b1;
        for (int i = 0; i < 18; i++) step(1'b1, 8'(i));
        step(1'b0, 8'h00);
        chk("ovf_full", {31'd0, bus.full}, 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd16);
`ifdef UART_TX_FIFO_OVF_STAT_EN
        chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
        chk("ovf_drop_cnt", {24'd0, bus.drop_cnt}, 32'd2);
`else
        chk("ovf_flag_off", {31'd0, bus.overflow}, 32'd0);
        chk("ovf_drop_cnt_off", {24'd0, bus.drop_cnt}, 32'd0);
`endif
        hold_busy = 1'b0;
        wait_idle(400);
        chk("ovf_n_sent", sent.size(), 32'd16);
        for (int i = 0; i < 16 && i < sent.size(); i++)
            chk("ovf_order", {24'd0, sent[i]}, i);

        // Stream with wrap and coinciding push/pop
        sent.delete();
        busy_len  = 3;
        max_count = 0;
        coinc     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i));
            for (int k = 0; k < 4; k++) step(1'b0, 8'h00);
        end
        wait_idle(600);
        chk("stream_n_sent", sent.size(), 32'd40);
        for (int i = 0; i < 40 && i < sent.size(); i++)
            chk("stream_order", {24'd0, sent[i]}, 32'h80 + i);
        chk("stream_coincide", {31'd0, coinc}, 32'd1);
        chk("stream_max_le_depth", {31'd0, max_count <= DEPTH}, 32'd1);

        // Reset while in the middle of a frame
        sent.delete();
        busy_len = 30;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i));
        step(1'b0, 8'h00);
        for (int i = 0; i < 20 && !bus.tx_busy; i++) step(1'b0, 8'h00);
        chk("mid_busy_up", {31'd0, bus.tx_busy}, 32'd1);
        step(1'b0, 8'h00);
        chk("mid_count", 32'(bus.count), 32'd5);
        rst = 1'b1;
        step(1'b0, 8'h00);
        rst = 1'b0;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("mid_rst_start", {31'd0, bus.tx_start}, 32'd0);
        chk("mid_rst_data", {24'd0, bus.tx_data}, 32'd0);
        for (int i = 0; i < 60 && bus.tx_busy; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h55);
        step(1'b0, 8'h00);
        wait_idle(200);
        chk("mid_n_sent", sent.size(), 32'd2);
        if (sent.size() >= 2) begin
            chk("mid_first", {24'd0, sent[0]}, 32'h60);
            chk("mid_after", {24'd0, sent[1]}, 32'h55);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
